bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_scan_driver.sv | 110 +++++++++++
 tb/tb_bcd_scan_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed 7-segment scanner for packed BCD input, with a ghost-guard dark cycle per slot.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_driver #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        bcd_valid,
  input  logic        blank,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        slot_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       idx, idx_next;
  logic [15:0]      disp, disp_next;
  logic             run;
  logic             wrap;
  logic [3:0]       digit;
  logic [3:0]       shown;
  logic [6:0]       glyph_q, glyph_next;
  logic             lit_q, lit_next;

  // The first cycle out of reset is treated as a slot boundary so slot 0 opens with its guard cycle.
  always_comb begin
    disp_next = bcd_valid ? bcd : disp;
    wrap      = !run || (cnt == CNT_LAST);
    cnt_next  = wrap ? '0 : cnt + 1'b1;
    if (!run)
      idx_next = 2'd0;
    else if (cnt == CNT_LAST)
      idx_next = idx + 2'd1;
    else
      idx_next = idx;

    case (idx_next)
      2'd0:    digit = disp_next[3:0];
      2'd1:    digit = disp_next[7:4];
      2'd2:    digit = disp_next[11:8];
      default: digit = disp_next[15:12];
    endcase

`ifdef BCD_SCAN_LZB_EN
    shown = {disp_next[15:12] != 4'd0,
             disp_next[15:8]  != 8'd0,
             disp_next[15:4]  != 12'd0,
             1'b1};
`else
    shown = 4'b1111;
`endif

    // Glyph and digit enable are latched only at slot boundaries, so mid-slot loads wait for the next slot.
    if (wrap) begin
      glyph_next = shown[idx_next] ? glyph(digit) : SEG_DARK;
      lit_next   = shown[idx_next];
    end else begin
      glyph_next = glyph_q;
      lit_next   = lit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 2'd0;
      disp      <= 16'd0;
      run       <= 1'b0;
      glyph_q   <= SEG_DARK;
      lit_q     <= 1'b0;
      seg_n     <= SEG_DARK;
      an_n      <= 4'b1111;
      slot_tick <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      idx       <= idx_next;
      disp      <= disp_next;
      run       <= 1'b1;
      glyph_q   <= glyph_next;
      lit_q     <= lit_next;
      slot_tick <= wrap;
      an_n      <= (wrap || blank || !lit_next) ? 4'b1111 : ~(4'b0001 << idx_next);
      seg_n     <= blank ? SEG_DARK : glyph_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver at CLK_DIV=4; expectations follow BCD_SCAN_LZB_EN when defined.
module tb_bcd_scan_driver;
  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        blank;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        slot_tick;

  int checks = 0;
  int errors = 0;

`ifdef BCD_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] DARK = 7'b1111111;

  logic [6:0] g1234 [4];

  bcd_scan_driver #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .blank     (blank),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .slot_tick (slot_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                         input logic tick_e);
    chk({tag, ".an_n"}, {4'b0, an_n}, {4'b0, an_e});
    chk({tag, ".seg_n"}, {1'b0, seg_n}, {1'b0, seg_e});
    chk({tag, ".slot_tick"}, {7'b0, slot_tick}, {7'b0, tick_e});
  endtask

  initial begin
    int s;
    int p;
    g1234[0] = G4;
    g1234[1] = G3;
    g1234[2] = G2;
    g1234[3] = G1;
    rst = 1'b1;
    bcd = 16'h0000;
    bcd_valid = 1'b0;
    blank = 1'b0;

    // reset held three cycles
    tick();
    chk_out("rst1", 4'b1111, DARK, 1'b0);
    tick();
    tick();
    chk_out("rst3", 4'b1111, DARK, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("guard0", 4'b1111, G0, 1'b1);
    tick();
    chk_out("slot0", 4'b1110, G0, 1'b0);

    // mid-slot load must not change the current slot
    bcd = 16'h1234;
    bcd_valid = 1'b1;
    tick();
    chk_out("midload", 4'b1110, G0, 1'b0);
    bcd_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      s = (1 + k / 4) % 4;
      p = k % 4;
      tick();
      chk_out($sformatf("scan1234.%0d", k), (p == 0) ? 4'b1111 : ~(4'b0001 << s), g1234[s], p == 0);
    end

    // 00A7 loaded on a wrap edge: tens slot opens with a dash
    bcd = 16'h00A7;
    bcd_valid = 1'b1;
    tick();
    chk_out("a7.guard1", 4'b1111, DASH, 1'b1);
    bcd_valid = 1'b0;
    tick();
    chk_out("a7.tens", 4'b1101, DASH, 1'b0);
    repeat (3) tick();
    tick();
    chk_out("a7.hund", LZB ? 4'b1111 : 4'b1011, LZB ? DARK : G0, 1'b0);
    repeat (4) tick();
    chk_out("a7.thou", LZB ? 4'b1111 : 4'b0111, LZB ? DARK : G0, 1'b0);
    repeat (4) tick();
    chk_out("a7.units", 4'b1110, G7, 1'b0);

    // blank for ten cycles while the scan keeps running
    blank = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_out($sformatf("blank.%0d", k), 4'b1111, DARK, (k == 2) || (k == 6));
    end
    blank = 1'b0;
    tick();
    chk_out("unblank.guard3", 4'b1111, LZB ? DARK : G0, 1'b1);
    tick();
    chk_out("unblank.thou", LZB ? 4'b1111 : 4'b0111, LZB ? DARK : G0, 1'b0);
    repeat (3) tick();
    tick();
    chk_out("unblank.units", 4'b1110, G7, 1'b0);

    // load coinciding with a slot wrap
    repeat (2) tick();
    bcd = 16'h9999;
    bcd_valid = 1'b1;
    tick();
    chk_out("wrapload.guard", 4'b1111, G9, 1'b1);
    bcd_valid = 1'b0;
    tick();
    chk_out("wrapload.tens", 4'b1101, G9, 1'b0);
    repeat (3) tick();
    tick();
    chk_out("slot2", 4'b1011, G9, 1'b0);

    // reset mid-slot 2, racing a load that reset must win
    rst = 1'b1;
    bcd = 16'h5555;
    bcd_valid = 1'b1;
    tick();
    chk_out("midrst", 4'b1111, DARK, 1'b0);
    rst = 1'b0;
    bcd_valid = 1'b0;
    tick();
    chk_out("restart.guard", 4'b1111, G0, 1'b1);
    tick();
    chk_out("restart.units", 4'b1110, G0, 1'b0);
    repeat (3) tick();
    tick();
    chk_out("restart.tens", LZB ? 4'b1111 : 4'b1101, LZB ? DARK : G0, 1'b0);

    // back-to-back loads: last one wins
    bcd = 16'h1111;
    bcd_valid = 1'b1;
    tick();
    bcd = 16'h2222;
    tick();
    bcd_valid = 1'b0;
    chk_out("b2b.hold", LZB ? 4'b1111 : 4'b1101, LZB ? DARK : G0, 1'b0);
    tick();
    chk_out("b2b.guard", 4'b1111, G2, 1'b1);
    tick();
    chk_out("b2b.hund", 4'b1011, G2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
